// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: FSM state encoding, parity modes
// and the frame-length clamp.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_e;

    typedef enum logic [2:0] {
        PARITY_NONE  = 3'd0,
        PARITY_EVEN  = 3'd1,
        PARITY_ODD   = 3'd2,
        PARITY_MARK  = 3'd3,
        PARITY_SPACE = 3'd4
    } parity_e;

    localparam logic [3:0] MIN_DATA = 4'd5;

    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
        if (len < MIN_DATA) return MIN_DATA;
        if (len > max_len)  return max_len;
        return len;
    endfunction

    // Codes 5..7 are reserved and behave exactly like "no parity".
    function automatic parity_e decode_parity(input logic [2:0] mode);
        return (mode > 3'd4) ? PARITY_NONE : parity_e'(mode);
    endfunction

endpackage

// File: rtl/uart_rx_core_bit_sampler.sv
// Line front end: 2-flop synchroniser, per-bit sample counter and 2-of-3 majority vote
// around the bit centre.
module uart_bit_sampler #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk_16bd,
    input  logic rst_n,
    input  logic rx_i,
    input  logic run_i,
    output logic rx_sync_o,
    output logic bit_strobe_o,
    output logic bit_value_o,
    output logic bit_end_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] S0   = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0] S1   = CW'(OVERSAMPLE/2);
    localparam logic [CW-1:0] S2   = CW'(OVERSAMPLE/2 + 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          s0_q;
    logic          s1_q;

    // NOTE: the synchroniser resets to 1 so the idle-high line never looks like a start bit.
    always_ff @(posedge clk_16bd or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            s0_q   <= 1'b1;
            s1_q   <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            if (!run_i || cnt_q == LAST) cnt_q <= '0;
            else                         cnt_q <= cnt_q + CW'(1);
            if (cnt_q == S0) s0_q <= sync_q[1];
            if (cnt_q == S1) s1_q <= sync_q[1];
        end
    end

    assign rx_sync_o    = sync_q[1];
    assign bit_strobe_o = run_i && (cnt_q == S2);
    assign bit_end_o    = run_i && (cnt_q == LAST);
    assign bit_value_o  = (s0_q & s1_q) | (s0_q & sync_q[1]) | (s1_q & sync_q[1]);

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: frame FSM plus a one-deep valid/ready output register
// carrying the received data and its error/break flags.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int MAX_DATA   = 9
) (
    input  logic                clk_16bd,
    input  logic                rst_n,
    input  logic                Rx,
    input  logic [3:0]          frame_length,
    input  logic [2:0]          parity_mode,
    input  logic                stop_bits,
    output logic [MAX_DATA-1:0] frame,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                parity_err,
    output logic                framing_err,
    output logic                break_det,
    output logic                overrun,
    output logic                rx_busy
);

    localparam logic [3:0] MAX_LEN = 4'(MAX_DATA);

    rx_state_e           state_q;
    logic [3:0]          len_q;
    parity_e             par_q;
    logic                two_stop_q;
    logic [MAX_DATA-1:0] data_q;
    logic [3:0]          data_cnt_q;
    logic                stop_idx_q;
    logic                perr_q, ferr_q, zero_q;
    logic [MAX_DATA-1:0] frame_q;
    logic                valid_q, perr_out_q, ferr_out_q, brk_out_q, overrun_q;

    logic rx_sync, bit_strobe, bit_value, bit_end, run;
    logic exp_par, last_stop, ferr_next, brk_next;

    assign run = (state_q == ST_START) || (state_q == ST_DATA) ||
                 (state_q == ST_PARITY) || (state_q == ST_STOP);

    uart_bit_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
        .clk_16bd     (clk_16bd),
        .rst_n        (rst_n),
        .rx_i         (Rx),
        .run_i        (run),
        .rx_sync_o    (rx_sync),
        .bit_strobe_o (bit_strobe),
        .bit_value_o  (bit_value),
        .bit_end_o    (bit_end)
    );

    always_comb begin
        case (par_q)
            PARITY_EVEN: exp_par = ^data_q;
            PARITY_ODD:  exp_par = ~^data_q;
            PARITY_MARK: exp_par = 1'b1;
            default:     exp_par = 1'b0;
        endcase
    end

    assign last_stop = (stop_idx_q == two_stop_q);
    assign ferr_next = ferr_q | ~bit_value;
    assign brk_next  = zero_q & ~bit_value;

    always_ff @(posedge clk_16bd or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            par_q      <= PARITY_NONE;
            two_stop_q <= 1'b0;
            data_q     <= '0;
            data_cnt_q <= '0;
            stop_idx_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b0;
            frame_q    <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_out_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (valid_q && frame_ready) valid_q <= 1'b0;

            case (state_q)
                ST_IDLE: if (!rx_sync) begin
                    state_q    <= ST_START;
                    len_q      <= clamp_len(frame_length, MAX_LEN);
                    par_q      <= decode_parity(parity_mode);
                    two_stop_q <= stop_bits;
                    data_q     <= '0;
                    data_cnt_q <= '0;
                    stop_idx_q <= 1'b0;
                    perr_q     <= 1'b0;
                    ferr_q     <= 1'b0;
                    zero_q     <= 1'b1;
                end
                ST_START: begin
                    if (bit_strobe && bit_value) state_q <= ST_IDLE;
                    else if (bit_end)            state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (bit_strobe) begin
                        data_q     <= data_q | (MAX_DATA'(bit_value) << data_cnt_q);
                        data_cnt_q <= data_cnt_q + 4'd1;
                        zero_q     <= zero_q & ~bit_value;
                    end
                    if (bit_end && data_cnt_q == len_q)
                        state_q <= (par_q == PARITY_NONE) ? ST_STOP : ST_PARITY;
                end
                ST_PARITY: begin
                    if (bit_strobe) begin
                        perr_q <= (bit_value != exp_par);
                        zero_q <= zero_q & ~bit_value;
                    end
                    if (bit_end) state_q <= ST_STOP;
                end
                ST_STOP: if (bit_strobe) begin
                    if (!last_stop) begin
                        stop_idx_q <= 1'b1;
                        ferr_q     <= ferr_next;
                        zero_q     <= brk_next;
                    end else begin
                        // Completion: finish on the vote, not at the end of the stop bit.
                        state_q <= brk_next ? ST_BREAK_WAIT : ST_IDLE;
                        if (!valid_q || frame_ready) begin
                            valid_q    <= 1'b1;
                            frame_q    <= brk_next ? '0 : data_q;
                            perr_out_q <= perr_q & ~brk_next;
                            ferr_out_q <= ferr_next;
                            brk_out_q  <= brk_next;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end
                end
                ST_BREAK_WAIT: if (rx_sync) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign frame       = frame_q;
    assign frame_valid = valid_q;
    assign parity_err  = perr_out_q;
    assign framing_err = ferr_out_q;
    assign break_det   = brk_out_q;
    assign overrun     = overrun_q;
    assign rx_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized frames
// compared against a frame-level behavioural model.
module tb_uart_rx_core;

    localparam int OS = 16;
    localparam int MD = 9;

    logic          clk_16bd = 1'b0;
    logic          rst_n = 1'b0;
    logic          Rx = 1'b1;
    logic [3:0]    frame_length = 4'd8;
    logic [2:0]    parity_mode = 3'd0;
    logic          stop_bits = 1'b0;
    logic          frame_ready = 1'b1;
    logic [MD-1:0] frame;
    logic          frame_valid, parity_err, framing_err, break_det, overrun, rx_busy;

    uart_rx_core #(.OVERSAMPLE(OS), .MAX_DATA(MD)) dut (
        .clk_16bd     (clk_16bd),
        .rst_n        (rst_n),
        .Rx           (Rx),
        .frame_length (frame_length),
        .parity_mode  (parity_mode),
        .stop_bits    (stop_bits),
        .frame        (frame),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .parity_err   (parity_err),
        .framing_err  (framing_err),
        .break_det    (break_det),
        .overrun      (overrun),
        .rx_busy      (rx_busy)
    );

    always #5 clk_16bd = ~clk_16bd;

    typedef struct packed {
        logic [MD-1:0] data;
        logic          perr;
        logic          ferr;
        logic          brk;
    } rec_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   valid_rises = 0;
    int   ovr_cnt = 0;
    int   start_cyc = 0;
    logic prev_valid = 1'b0;
    rec_t got_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_16bd) cyc++;

    // Accepted frames are captured half a cycle before the consuming edge.
    always @(negedge clk_16bd) begin
        rec_t r;
        if (frame_valid && !prev_valid) begin
            rise_cyc = cyc;
            valid_rises++;
        end
        prev_valid = frame_valid;
        if (frame_valid && frame_ready) begin
            r.data = frame;
            r.perr = parity_err;
            r.ferr = framing_err;
            r.brk  = break_det;
            got_q.push_back(r);
        end
        if (overrun) ovr_cnt++;
    end

    function automatic int eff_len(input int len);
        return (len < 5) ? 5 : ((len > MD) ? MD : len);
    endfunction

    function automatic bit has_parity(input int pm);
        return (pm >= 1) && (pm <= 4);
    endfunction

    // Frame-level reference: what a receiver must report for a frame as put on the line.
    function automatic rec_t model(input logic [MD-1:0] d, input int len, input int pm,
                                   input bit two, input bit pbit, input bit s0, input bit s1);
        rec_t r;
        int   n = eff_len(len);
        int   dv = int'(d) & ((1 << n) - 1);
        int   ones = $countones(dv);
        bit   exp_p;
        case (pm)
            1:       exp_p = ones[0];
            2:       exp_p = ~ones[0];
            3:       exp_p = 1'b1;
            default: exp_p = 1'b0;
        endcase
        r.data = MD'(dv);
        r.perr = has_parity(pm) && (pbit != exp_p);
        r.ferr = !s0 || (two && !s1);
        r.brk  = (dv == 0) && !(has_parity(pm) && pbit) && !s0 && !(two && s1);
        if (r.brk) begin
            r.data = '0;
            r.perr = 1'b0;
        end
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk_16bd);
        #1;
    endtask

    task automatic drive_bit(input bit b);
        Rx = b;
        idle(OS);
    endtask

    // Called at posedge+1; the format is scrambled after the start bit to prove it was latched.
    task automatic send_frame(input logic [MD-1:0] d, input int len, input int pm,
                              input bit two, input bit pbit, input bit s0, input bit s1);
        int n = eff_len(len);
        frame_length = 4'(len);
        parity_mode  = 3'(pm);
        stop_bits    = two;
        start_cyc    = cyc + 1;
        drive_bit(1'b0);
        frame_length = 4'($urandom);
        parity_mode  = 3'($urandom);
        stop_bits    = 1'($urandom);
        for (int i = 0; i < n; i++) drive_bit(d[i]);
        if (has_parity(pm)) drive_bit(pbit);
        drive_bit(s0);
        if (two) drive_bit(s1);
        Rx = 1'b1;
    endtask

    task automatic expect_frame(input string tag, input rec_t exp);
        rec_t g;
        check({tag, "_count"}, 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            check({tag, "_data"}, 32'(g.data), 32'(exp.data));
            check({tag, "_perr"}, 32'(g.perr), 32'(exp.perr));
            check({tag, "_ferr"}, 32'(g.ferr), 32'(exp.ferr));
            check({tag, "_brk"},  32'(g.brk),  32'(exp.brk));
        end
        got_q.delete();
    endtask

    initial begin
        int   rises0, ovr0, t_on, t_off;
        bit   seen;
        logic [MD-1:0] d;
        int   len, pm;
        bit   two, pbit;

        #2;
        check("reset_outputs", 32'({frame, frame_valid, parity_err, framing_err, break_det, overrun, rx_busy}), 32'd0);
        #21 rst_n = 1'b1;
        idle(3);
        check("idle_busy", 32'(rx_busy), 32'd0);

        // 8N1 0xA5 with latency from the falling edge
        send_frame(9'h0A5, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(4);
        check("8n1_latency", 32'(rise_cyc - start_cyc), 32'd156);
        expect_frame("8n1_a5", model(9'h0A5, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1));

        // 7E2, 0x41 with a wrong parity bit
        send_frame(9'h041, 7, 1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(4);
        expect_frame("7e2_bad_par", model(9'h041, 7, 1, 1'b1, 1'b1, 1'b1, 1'b1));

        // 9O1, 0x1FF with correct parity and the stop bit low
        send_frame(9'h1FF, 9, 2, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(40);
        expect_frame("9o1_stop0", model(9'h1FF, 9, 2, 1'b0, 1'b0, 1'b0, 1'b1));

        // Quarter-bit glitch must be rejected
        rises0 = valid_rises;
        seen = 1'b0;
        t_on = 0;
        t_off = 0;
        frame_length = 4'd8;
        parity_mode = 3'd0;
        stop_bits = 1'b0;
        Rx = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) Rx = 1'b1;
            idle(1);
            if (rx_busy && !seen) begin
                seen = 1'b1;
                t_on = i;
            end
            if (!rx_busy && seen && t_off == 0) t_off = i;
        end
        check("glitch_busy_seen", 32'(seen), 32'd1);
        check("glitch_busy_drop_ok", 32'((t_off > t_on) && (t_off - t_on <= 11)), 32'd1);
        check("glitch_no_valid", 32'(valid_rises - rises0), 32'd0);
        got_q.delete();

        // Line break: 20 bit times low
        Rx = 1'b0;
        idle(20 * OS);
        check("break_busy_held", 32'(rx_busy), 32'd1);
        Rx = 1'b1;
        idle(6);
        check("break_busy_released", 32'(rx_busy), 32'd0);
        check("break_flag_held", 32'(break_det), 32'd1);
        expect_frame("break", model(9'h000, 8, 0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Overrun: two frames with the consumer stalled
        frame_ready = 1'b0;
        ovr0 = ovr_cnt;
        send_frame(9'h012, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(9'h034, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(10);
        check("ovr_pulse_cycles", 32'(ovr_cnt - ovr0), 32'd1);
        check("ovr_valid_held", 32'(frame_valid), 32'd1);
        check("ovr_frame_held", 32'(frame), 32'h012);
        frame_ready = 1'b1;
        idle(4);
        expect_frame("ovr_drain", model(9'h012, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1));
        check("ovr_valid_cleared", 32'(frame_valid), 32'd0);
        check("ovr_data_kept", 32'(frame), 32'h012);

        // Randomized formats, data and parity bits against the model
        for (int k = 0; k < 30; k++) begin
            d    = MD'($urandom);
            len  = $urandom_range(0, 15);
            pm   = $urandom_range(0, 7);
            two  = 1'($urandom);
            pbit = 1'($urandom);
            send_frame(d, len, pm, two, pbit, 1'b1, 1'b1);
            idle(3);
            expect_frame($sformatf("rnd%0d", k), model(d, len, pm, two, pbit, 1'b1, 1'b1));
        end

        // Asynchronous reset in the middle of the data bits
        rises0 = valid_rises;
        frame_length = 4'd8;
        parity_mode = 3'd0;
        stop_bits = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        idle(5);
        #3 rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs", 32'({frame, frame_valid, parity_err, framing_err, break_det, overrun, rx_busy}), 32'd0);
        Rx = 1'b1;
        #7 rst_n = 1'b1;
        idle(300);
        check("post_reset_no_valid", 32'(valid_rises - rises0), 32'd0);
        check("post_reset_idle", 32'({frame_valid, rx_busy}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receiver and the successor to the current fixed 16× processor. It runs on the oversampling clock and takes the raw serial line. It uses majority-vote sampling, runtime-selectable frame format (5–MAX_DATA data bits, five parity modes, 1/2 stop bits) and error/break reporting. Completed frames go out through a valid/ready handshake to the downstream command/pixel logic.

## Interface
- OVERSAMPLE, 16: clock cycles per bit; even, ≥8.
- MAX_DATA, 9: maximum data bits; 5..9.
- clk_16bd  in  1  oversampling clock, OVERSAMPLE × baud.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- Rx  in  1  raw serial line, idle high, asynchronous to clk_16bd.
- frame_length  in  4  data bits per frame; <5 is treated as 5, >MAX_DATA as MAX_DATA.
- parity_mode  in  3  0 none, 1 even, 2 odd, 3 mark, 4 space; 5–7 act as none.
- stop_bits  in  1  0 = one stop bit, 1 = two.
- frame  out  MAX_DATA  received data, LSB-first on the line, right-aligned, unused MSBs 0.
- frame_valid  out  1  frame and its flags are valid.
- frame_ready  in  1  consumer accepts the frame.
- parity_err  out  1  parity mismatch for the held frame.
- framing_err  out  1  a stop bit voted 0 for the held frame.
- break_det  out  1  held frame is a line break.
- overrun  out  1  one-cycle pulse: a completed frame was discarded.
- rx_busy  out  1  receiver is not in IDLE.

## Operation
- Rx passes through a 2-flop synchroniser (reset value 1) before any use.
- Each bit is decided by a 2-of-3 majority of synchronised samples at counts OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- The sample counter wraps at OVERSAMPLE−1; that wrap is the bit boundary.
- States: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE:
  - Synchronised Rx low → START with sample count 0.
  - frame_length, parity_mode and stop_bits are latched on this same cycle. Mid-frame changes are ignored.
- START:
  - Vote 1 → IDLE (glitch rejected, no output, no flags).
  - Vote 0 → DATA at the boundary.
- DATA:
  - Each vote is shifted into bit position data_count.
  - After the latched length → PARITY if a parity mode is active, else STOP.
- Expected parity bit:
  - even: XOR of the data bits.
  - odd: the inverse of that XOR.
  - mark: 1.
  - space: 0.
  - parity_err = vote ≠ expected.
- STOP: one or two stop bits. Any stop vote of 0 sets framing_err.
- Frame completion: at the final vote of the last stop bit. With two stop bits this is the second stop bit, even if the first already failed. Next state is IDLE, so the remaining half stop bit is not waited out.
- Break: all data bits 0, parity vote 0 (if enabled) and all stops 0.
  - Sets break_det and framing_err; frame = 0.
  - State goes to BREAK_WAIT, which holds until synchronised Rx is 1, then IDLE.
- Errored frames are delivered with their flags, never silently dropped.
- Output register:
  - Completion with frame_valid=0, or frame_valid=1 with frame_ready=1 in the same cycle → load frame and flags, frame_valid=1.
  - Completion while frame_valid=1 and frame_ready=0 → keep the old frame, discard the new one, pulse overrun for 1 cycle.
  - frame_valid=1 with frame_ready=1 and no completion → frame_valid=0. Data and flags are held until the next load.
- Reset values: frame=0, frame_valid=0, all flags 0, overrun=0, rx_busy=0, state IDLE, all counters 0.
- Reset mid-frame: immediate abort, no partial frame, no flags.

## Timing
- Line falling edge at input cycle 0 → START entered at cycle 2 (synchroniser).
- N = 1 + data bits + parity bit + stop bits. Last vote at cycle 2 + (N−1)·OVERSAMPLE + OVERSAMPLE/2 + 1. frame_valid rises the next cycle.
- A new start bit is accepted in the first IDLE cycle after completion.
- rx_busy is high from the START cycle through the completion cycle, and through BREAK_WAIT.
- frame_ready is sampled only while frame_valid=1.

## Structure
- Shared package uart_pkg: state encoding, PARITY_NONE/EVEN/ODD/MARK/SPACE constants, and the clamp function for frame_length.
- Sub-module uart_bit_sampler: synchroniser, sample counter and 3-sample majority vote. It outputs a bit_strobe and a bit_value.
- FSM and output register live in uart_rx_core.

## Test plan
- 8N1, OVERSAMPLE=16, byte 0xA5, frame_ready=1 → frame=0x0A5, frame_valid high at cycle 156, all flags 0.
- 7E2, data 0x41 with parity bit 1 (wrong) → frame=0x041, parity_err=1, framing_err=0.
- 9O1, data 0x1FF, stop bit driven 0 → frame=0x1FF, framing_err=1.
- A 0.25-bit low pulse (4 cycles) on an idle line → rx_busy drops within 11 cycles of START entry, no frame_valid. Then 20 bit times low → break_det=1, framing_err=1, frame=0, rx_busy held until Rx returns high.
- Two back-to-back 8N1 frames 0x12, 0x34 with frame_ready=0 → first frame held, overrun pulses 1 cycle at the second completion. Setting frame_ready=1 then yields 0x12 only.
- rst_n asserted at mid-data of a frame → all outputs 0 asynchronously. After release with Rx high, no frame_valid.
